// File: rtl/popcount_accum_stage_pkg.sv
// Shared definitions for the popcount accumulator stage: default widths and FSM encoding.
package popcount_accum_stage_pkg;

  localparam int unsigned WORD_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 6;
  localparam int unsigned ACC_W_DEF  = 38;
  localparam int unsigned WCNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/popcount_accum_stage_popcount32.sv
// Combinational population count of one input word.
module popcount32
  import popcount_accum_stage_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic [WORD_W-1:0] data,
  output logic [CNT_W-1:0]  count_c
);

  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      count_c = count_c + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/popcount_accum_stage.sv
// Streaming popcount accumulator: counts set bits of each accepted word into a saturating total
// and presents total, word count and overflow on a held result handshake at end of frame.
module popcount_accum_stage
  import popcount_accum_stage_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned WCNT_W = WCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_total,
  output logic [WCNT_W-1:0] out_words,
  output logic              out_overflow
);

  localparam int unsigned SUM_W = ACC_W + 1;

  state_e            state_q;
  state_e            state_d;
  logic              accept_c;
  logic              clear_c;
  logic [CNT_W-1:0]  pc_c;
  logic [CNT_W-1:0]  pc_q;
  logic              pc_v_q;
  logic [SUM_W-1:0]  sum_c;

  assign accept_c = in_valid & in_ready;
  assign clear_c  = (state_q == ST_IDLE) & start;

  popcount32 #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_popcount (
    .data    (in_data),
    .count_c (pc_c)
  );

  // Next-state logic; DRAIN waits for the last popcount to land in the accumulator.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)                 state_d = ST_ACCUM;
      ST_ACCUM: if (accept_c && in_last)   state_d = ST_DRAIN;
      ST_DRAIN: if (!pc_v_q)               state_d = ST_DONE;
      ST_DONE:  if (out_ready)             state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are registered copies of the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == ST_ACCUM);
      out_valid <= (state_d == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      pc_v_q <= 1'b0;
    end else begin
      pc_v_q <= accept_c;
      if (accept_c) pc_q <= pc_c;
    end
  end

  assign sum_c = {1'b0, out_total} + SUM_W'(pc_q);

  // Saturating accumulate; overflow stays set until the next frame opens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_total    <= '0;
      out_overflow <= 1'b0;
    end else if (clear_c) begin
      out_total    <= '0;
      out_overflow <= 1'b0;
    end else if (pc_v_q) begin
      if (sum_c[ACC_W]) begin
        out_total    <= '1;
        out_overflow <= 1'b1;
      end else begin
        out_total <= sum_c[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_words <= '0;
    end else if (clear_c) begin
      out_words <= '0;
    end else if (accept_c && (out_words != '1)) begin
      out_words <= out_words + WCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_popcount_accum_stage.sv
// Randomized self-checking bench: a full-width instance plus a narrow instance that saturates easily.
module tb_popcount_accum_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [37:0] out_total;
  logic [15:0] out_words;
  logic        out_overflow;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [7:0]  s_total;
  logic [2:0]  s_words;
  logic        s_overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] words_q[$];

  always #5 clk = ~clk;

  popcount_accum_stage dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_total(out_total), .out_words(out_words), .out_overflow(out_overflow)
  );

  popcount_accum_stage #(.ACC_W(8), .WCNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_total(s_total), .out_words(s_words), .out_overflow(s_overflow)
  );

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned clamp(input longint unsigned v, input int w);
    longint unsigned mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

  // Offers words_q as one frame, then checks latency, results, hold behaviour and return to idle.
  task automatic run_frame(input int hold, input bit gaps);
    longint unsigned tot = 0;
    int n = words_q.size();
    int idx = 0;
    int cyc = 0;
    int lat;
    bit acc_now;
    foreach (words_q[i]) tot += longint'($countones(words_q[i]));

    // idle garbage and a word offered alongside start must not be taken
    in_valid = 1'b1; in_data = $urandom; in_last = 1'b1;
    @(posedge clk); #1;
    check("idle_rdy", in_ready, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rdy_after_start", in_ready, 1);
    check("s_rdy_after_start", s_in_ready, 1);

    while (idx < n && cyc < 1000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = words_q[idx];
      in_last  = (idx == n - 1);
      acc_now  = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc_now) idx++;
    end
    if (cyc >= 1000) check("accept_timeout", idx, n);

    in_valid = 1'b1; in_data = $urandom; in_last = 1'($urandom_range(0, 1));
    check("rdy_after_last", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 3);
    check("s_out_valid", s_out_valid, 1);
    check("total", out_total, clamp(tot, 38));
    check("words", out_words, clamp(longint'(n), 16));
    check("ovf", out_overflow, tot > clamp(tot, 38));
    check("s_total", s_total, clamp(tot, 8));
    check("s_words", s_words, clamp(longint'(n), 3));
    check("s_ovf", s_overflow, tot > clamp(tot, 8));

    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_total", out_total, clamp(tot, 38));
      check("hold_words", out_words, clamp(longint'(n), 16));
      check("hold_rdy", in_ready, 0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("idle_rdy_a", in_ready, 0);
    @(posedge clk); #1;
    check("idle_rdy_b", in_ready, 0);
    check("retain_total", out_total, clamp(tot, 38));
    check("retain_s_total", s_total, clamp(tot, 8));
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_total", out_total, 0);
    check("rst_words", out_words, 0);
    check("rst_ovf", out_overflow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    words_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_frame(0, 1'b0);

    words_q = '{32'h0000_0000, 32'h8000_0001, 32'h0000_FFFF};
    run_frame(5, 1'b0);

    // narrow instance reaches 246, then saturates and stays saturated; its word count pins at 7
    words_q = {};
    repeat (7) words_q.push_back(32'hFFFF_FFFF);
    words_q.push_back(32'h003F_FFFF);
    words_q.push_back(32'hFFFF_FFFF);
    words_q.push_back(32'h0000_0003);
    run_frame(1, 1'b0);

    words_q = '{32'h0000_0001};
    run_frame(0, 1'b1);

    for (int f = 0; f < 20; f++) begin
      int n = (f < 5) ? 10 : $urandom_range(1, 12);
      words_q = {};
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
      run_frame($urandom_range(0, 3), 1'b1);
    end

    // asynchronous reset with two words accepted and one still in the pipe
    in_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_last = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_total", out_total, 32);
    check("pre_rst_words", out_words, 2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_total", out_total, 0);
    check("async_words", out_words, 0);
    check("async_rdy", in_ready, 0);
    check("async_valid", out_valid, 0);
    check("async_ovf", out_overflow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    words_q = '{32'h0000_00FF, 32'h0F00_0000};
    run_frame(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
